// File: rtl/imem_port_arbiter_if.sv
// ============================================================================
// Module : imem_port_arbiter_if
// Brief  : Fetch, loader and byte-wide instruction-memory signals of the
//          instruction-memory port arbiter, with requester/arbiter modports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface imem_port_arbiter_if;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_err;
  logic        load_req;
  logic [63:0] load_addr;
  logic [31:0] load_data;
  logic        load_gnt;
  logic        load_done;
  logic        load_err;
  logic        busy;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  // Requesters and the memory together form the master side.
  modport master (
    output fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
    input  fetch_gnt, fetch_valid, fetch_instr, fetch_err,
           load_gnt, load_done, load_err, busy, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
    output fetch_gnt, fetch_valid, fetch_instr, fetch_err,
           load_gnt, load_done, load_err, busy, mem_addr, mem_we, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/imem_port_arbiter.sv
// ============================================================================
// Module : imem_port_arbiter
// Brief  : Shares a byte-wide instruction memory port between fetch (32-bit
//          reads) and the program loader (32-bit writes), little-endian.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_port_arbiter #(
  parameter int MEM_BYTES    = 256,
  parameter bit LOADER_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  imem_port_arbiter_if.slave bus
);

  localparam logic [2:0]  c_IDLE     = 3'd0;
  localparam logic [2:0]  c_RD       = 3'd1;
  localparam logic [2:0]  c_RD_LAST  = 3'd2;
  localparam logic [2:0]  c_WR       = 3'd3;
  localparam logic [2:0]  c_ERR      = 3'd4;
  localparam logic [63:0] c_MAX_BASE = 64'(MEM_BYTES - 4);

  logic [2:0]  state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [63:0] base_q, base_d;
  logic [31:0] data_q, data_d;
  logic        id_q, id_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [31:0] fetch_instr_q, fetch_instr_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        load_done_q, load_done_d;

  logic        w_pick_load;
  logic        w_pick_fetch;
  logic        w_accept;
  logic [63:0] w_addr;
  logic [63:0] w_next_addr;
  logic        w_bad;

  assign w_pick_load  = bus.load_req && (LOADER_FIRST || !bus.fetch_req);
  assign w_pick_fetch = bus.fetch_req && !w_pick_load;
  assign w_accept     = (state_q == c_IDLE) && (w_pick_load || w_pick_fetch);
  assign w_addr       = w_pick_load ? bus.load_addr : bus.fetch_addr;
  // Full 64-bit compare so addresses near 2^64 never wrap into range.
  assign w_bad        = (w_addr[1:0] != 2'b00) || (w_addr > c_MAX_BASE);
  assign w_next_addr  = base_q + {62'd0, k_q} + 64'd1;

  always_comb begin : p_next_state
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          if (w_bad)            state_d = c_ERR;
          else if (w_pick_load) state_d = c_WR;
          else                  state_d = c_RD;
        end
      end
      c_RD:      if (k_q == 2'd3) state_d = c_RD_LAST;
      c_RD_LAST: state_d = c_IDLE;
      c_WR:      if (k_q == 2'd3) state_d = c_IDLE;
      c_ERR:     state_d = c_IDLE;
      default:   state_d = c_IDLE;
    endcase
  end

  always_comb begin : p_outputs
    k_d           = k_q;
    base_d        = base_q;
    data_d        = data_q;
    id_d          = id_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    fetch_instr_d = fetch_instr_q;
    fetch_valid_d = 1'b0;
    load_done_d   = 1'b0;
    bus.fetch_gnt = (state_q == c_IDLE) && w_pick_fetch;
    bus.load_gnt  = (state_q == c_IDLE) && w_pick_load;
    bus.busy      = (state_q != c_IDLE);
    bus.fetch_err = (state_q == c_ERR) && !id_q;
    bus.load_err  = (state_q == c_ERR) && id_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          base_d = w_addr;
          data_d = bus.load_data;
          id_d   = w_pick_load;
          k_d    = 2'd0;
          if (!w_bad) begin
            mem_addr_d = w_addr;
            mem_we_d   = w_pick_load;
            if (w_pick_load) mem_wdata_d = bus.load_data[7:0];
          end
        end
      end
      c_RD: begin
        k_d = k_q + 2'd1;
        // Read data lags the address by one cycle, so byte k-1 arrives now.
        if (k_q != 2'd0) data_d = {bus.mem_rdata, data_q[31:8]};
        if (k_q != 2'd3) mem_addr_d = w_next_addr;
      end
      c_RD_LAST: begin
        fetch_instr_d = {bus.mem_rdata, data_q[31:8]};
        fetch_valid_d = 1'b1;
      end
      c_WR: begin
        k_d = k_q + 2'd1;
        if (k_q != 2'd3) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = w_next_addr;
          mem_wdata_d = data_q[15:8];
          data_d      = data_q >> 8;
        end else begin
          load_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : p_regs
    if (reset) begin
      state_q       <= c_IDLE;
      k_q           <= 2'd0;
      base_q        <= 64'd0;
      data_q        <= 32'd0;
      id_q          <= 1'b0;
      mem_addr_q    <= 64'd0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 8'd0;
      fetch_instr_q <= 32'd0;
      fetch_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      base_q        <= base_d;
      data_q        <= data_d;
      id_q          <= id_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_valid_q <= fetch_valid_d;
      load_done_q   <= load_done_d;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.fetch_instr = fetch_instr_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.load_done   = load_done_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// ============================================================================
// Module : tb_imem_port_arbiter
// Brief  : Self-checking bench for imem_port_arbiter with a byte memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_port_arbiter;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  imem_port_arbiter_if bus ();

  imem_port_arbiter #(
    .MEM_BYTES    (256),
    .LOADER_FIRST (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous byte memory driven by the DUT
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_we && bus.mem_addr < 64'd256) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= (bus.mem_addr < 64'd256) ? mem[bus.mem_addr[7:0]] : 8'h00;
  end

  typedef struct {
    bit          is_load;
    logic [63:0] addr;
    logic [31:0] data;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [3:0]  code;   // {fetch_valid, fetch_err, load_done, load_err}
    logic [31:0] instr;
    int          due;
  } exp_t;

  vec_t       vecs [12];
  exp_t       sb [$];
  logic [7:0] ref_mem [256];

  int   s_cyc;
  logic s_fgnt, s_lgnt, s_we, s_busy, s_zero;
  int   g_fetch_cyc, g_load_cyc;

  function automatic logic [31:0] ref_word(input logic [63:0] a);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++)
      if (a + 64'(k) < 64'd256) w[8*k +: 8] = ref_mem[a[7:0] + 8'(k)];
    return w;
  endfunction

  // Snapshot at the falling edge, then retire any completion pulse.
  task automatic mon();
    logic [3:0] obs;
    exp_t       e;
    s_cyc  = cyc;
    s_fgnt = bus.fetch_gnt;
    s_lgnt = bus.load_gnt;
    s_we   = bus.mem_we;
    s_busy = bus.busy;
    s_zero = ({bus.fetch_gnt, bus.fetch_valid, bus.fetch_instr, bus.fetch_err,
               bus.load_gnt, bus.load_done, bus.load_err, bus.busy,
               bus.mem_addr, bus.mem_we, bus.mem_wdata} == '0);
    if (!reset) begin
      obs = {bus.fetch_valid, bus.fetch_err, bus.load_done, bus.load_err};
      if (obs != 4'b0000) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_completion cycle=%0d got=%b required=none", cyc, obs);
        end else begin
          e = sb.pop_front();
          if (obs != e.code || cyc != e.due || (obs[3] && bus.fetch_instr != e.instr)) begin
            failures++;
            $display("FAIL completion got code=%b cycle=%0d instr=%h required code=%b cycle=%0d instr=%h",
                     obs, cyc, bus.fetch_instr, e.code, e.due, e.instr);
          end
        end
        if ((obs[2] || obs[0]) && bus.mem_we) begin
          checks++;
          failures++;
          $display("FAIL err_mem_we got=1 required=0");
        end
      end
      if (bus.mem_we) begin
        checks++;
        if (bus.mem_addr >= 64'd256) begin
          failures++;
          $display("FAIL write_range got addr=%h required <100", bus.mem_addr);
        end
      end
      if (bus.fetch_gnt && bus.load_gnt) begin
        checks++;
        failures++;
        $display("FAIL dual_grant got both required one");
      end
    end
  endtask

  // One clock: sample at negedge, return at the drive point after posedge.
  task automatic next_cycle();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit f_en, input logic [63:0] fa, input bit f_err,
                       input bit l_en, input logic [63:0] la, input logic [31:0] ld,
                       input bit l_err);
    bit   f_pend, l_pend;
    int   n;
    exp_t e;
    bus.fetch_req  = f_en;
    bus.fetch_addr = fa;
    bus.load_req   = l_en;
    bus.load_addr  = la;
    bus.load_data  = ld;
    f_pend = f_en;
    l_pend = l_en;
    n = 0;
    while ((f_pend || l_pend) && n < 60) begin
      next_cycle();
      n++;
      if (l_pend && s_lgnt) begin
        l_pend = 0;
        bus.load_req = 1'b0;
        g_load_cyc = s_cyc;
        e.code  = l_err ? 4'b0001 : 4'b0010;
        e.instr = 32'h0;
        e.due   = s_cyc + (l_err ? 1 : 5);
        sb.push_back(e);
        if (!l_err)
          for (int k = 0; k < 4; k++) ref_mem[la[7:0] + 8'(k)] = ld[8*k +: 8];
      end
      if (f_pend && s_fgnt) begin
        f_pend = 0;
        bus.fetch_req = 1'b0;
        g_fetch_cyc = s_cyc;
        e.code  = f_err ? 4'b0100 : 4'b1000;
        e.instr = ref_word(fa);
        e.due   = s_cyc + (f_err ? 1 : 6);
        sb.push_back(e);
      end
    end
    if (f_pend || l_pend) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout got pending fetch=%0d load=%0d required granted", f_pend, l_pend);
      bus.fetch_req = 1'b0;
      bus.load_req  = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      next_cycle();
      n++;
    end while ((sb.size() != 0 || s_busy) && n < 40);
    if (sb.size() != 0 || s_busy) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got pending=%0d busy=%0d required 0", sb.size(), s_busy);
      sb.delete();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    g_fetch_cyc = 0;
    g_load_cyc = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    reset = 1'b1;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = 64'h0;
    bus.load_req   = 1'b0;
    bus.load_addr  = 64'h0;
    bus.load_data  = 32'h0;

    vecs[0]  = '{1'b1, 64'h10,               32'h00188893, 1'b0};
    vecs[1]  = '{1'b0, 64'h10,               32'h0,        1'b0};
    vecs[2]  = '{1'b1, 64'hFC,               32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b0, 64'hFC,               32'h0,        1'b0};
    vecs[4]  = '{1'b0, 64'h22,               32'h0,        1'b1};
    vecs[5]  = '{1'b1, 64'h100,              32'hCAFEF00D, 1'b1};
    vecs[6]  = '{1'b0, 64'hFFFFFFFFFFFFFFFC, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 64'h20,               32'hA5C30F71, 1'b0};
    vecs[8]  = '{1'b0, 64'h20,               32'h0,        1'b0};
    vecs[9]  = '{1'b1, 64'h21,               32'h12345678, 1'b1};
    vecs[10] = '{1'b0, 64'h100,              32'h0,        1'b1};
    vecs[11] = '{1'b0, 64'h10,               32'h0,        1'b0};

    repeat (3) next_cycle();
    checks++;
    if (!s_zero) begin
      failures++;
      $display("FAIL reset_outputs got nonzero required all zero");
    end
    reset = 1'b0;
    next_cycle();
    checks++;
    if (!s_zero || s_busy) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%0d zero=%0d required busy=0 zero=1", s_busy, s_zero);
    end

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_load) issue(1'b0, 64'h0, 1'b0, 1'b1, vecs[i].addr, vecs[i].data, vecs[i].exp_err);
      else                 issue(1'b1, vecs[i].addr, vecs[i].exp_err, 1'b0, 64'h0, 32'h0, 1'b0);
      drain();
    end

    // Simultaneous requests: loader first, fetch granted in the load_done cycle
    issue(1'b1, 64'h30, 1'b0, 1'b1, 64'h30, 32'h11223344, 1'b0);
    checks++;
    if (g_fetch_cyc != g_load_cyc + 5) begin
      failures++;
      $display("FAIL simul_grant got fetch_gnt_cycle=%0d required=%0d", g_fetch_cyc, g_load_cyc + 5);
    end
    drain();

    // Reset in the third cycle of a write
    bus.load_req  = 1'b1;
    bus.load_addr = 64'h40;
    bus.load_data = 32'h55667788;
    next_cycle();
    checks++;
    if (!s_lgnt) begin
      failures++;
      $display("FAIL rst_wr_grant got=0 required=1");
    end
    bus.load_req = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    checks++;
    if (!s_we) begin
      failures++;
      $display("FAIL rst_wr_active got mem_we=0 required=1");
    end
    reset = 1'b0;
    next_cycle();
    checks++;
    if (!s_zero) begin
      failures++;
      $display("FAIL rst_mid_write got nonzero outputs required all zero");
    end
    repeat (8) next_cycle();

    // Recovery after the abandoned write
    issue(1'b0, 64'h0, 1'b0, 1'b1, 64'h50, 32'h0BADC0DE, 1'b0);
    drain();
    issue(1'b1, 64'h50, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single byte-wide port of the instruction memory between two requesters:
  - the fetch stage, which reads 32-bit instructions;
  - the program loader, which writes 32-bit instruction words at boot or debug time.
- Sequences each 32-bit transfer as four byte accesses in little-endian order (byte k at address base+k).
- Reads are assembled into one instruction word. Writes are split from one load word.
- Sits between the IF stage or loader and the instruction memory.

Parameters:
- MEM_BYTES, 256, number of addressable instruction bytes; accesses must satisfy base+3 < MEM_BYTES.
- LOADER_FIRST, 1, 1 = loader wins simultaneous requests; 0 = fetch wins.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request; level, held until fetch_gnt.
- fetch_addr  in  64  byte address of the instruction; stable while fetch_req=1.
- fetch_gnt  out  1  one-cycle pulse in the cycle the fetch request is accepted.
- fetch_valid  out  1  one-cycle pulse; fetch_instr is valid.
- fetch_instr  out  32  assembled instruction; holds its value until the next fetch completes.
- fetch_err  out  1  one-cycle pulse; misaligned or out-of-range fetch.
- load_req  in  1  loader write request; level, held until load_gnt.
- load_addr  in  64  byte address of the word to write.
- load_data  in  32  word to write.
- load_gnt  out  1  one-cycle acceptance pulse.
- load_done  out  1  one-cycle pulse; all four bytes written.
- load_err  out  1  one-cycle pulse; misaligned or out-of-range write, no bytes written.
- busy  out  1  high in every state except IDLE.
- mem_addr  out  64  byte address to the memory.
- mem_we  out  1  byte write enable.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; synchronous, valid the cycle after mem_addr is presented with mem_we=0.

Behaviour:
- Reset values:
  - All outputs are 0: fetch_gnt, fetch_valid, fetch_instr, fetch_err, load_gnt, load_done, load_err, busy, mem_addr, mem_we, mem_wdata.
  - State is IDLE and the byte counter is 0.
- Reset mid-operation: the transfer is abandoned with no done, valid or err pulse. mem_we is 0 from the first cycle after the reset edge. A partial write may leave 1-3 bytes written; this is permitted.
- States: IDLE, RD, RD_LAST, WR, ERR.
- Arbitration (IDLE only):
  - Grant is combinational from the requests and is not preemptive.
  - If both requests are asserted, LOADER_FIRST selects the winner; the loser stays pending.
  - On acceptance in cycle T:
    - assert the grant pulse;
    - latch the base address, load_data and the requester id;
    - clear the byte counter k.
- Address check at acceptance:
  - addr[1:0] != 0, or addr > MEM_BYTES-4 (unsigned 64-bit compare), goes to ERR.
  - ERR lasts one cycle (T+1): pulse fetch_err or load_err, no memory access, then IDLE.
- Read (fetch):
  - IDLE goes to RD at T+1.
  - RD cycles T+1..T+4: mem_addr = base+k with k = 0..3, mem_we = 0, k increments.
  - Bytes are captured at the end of T+2..T+5 into fetch_instr[8k+7:8k]. The T+5 capture (byte 3) happens in RD_LAST, where mem_addr holds base+3.
  - RD_LAST is T+5. fetch_valid pulses in T+6 and the state is IDLE in T+6.
  - Total latency from grant to valid: 6 cycles.
- Write (loader):
  - WR cycles T+1..T+4: mem_we = 1, mem_addr = base+k, mem_wdata = data[8k+7:8k].
  - load_done pulses in T+5 with the state in IDLE.
- Back-to-back: the IDLE cycle that carries a done or valid pulse may accept a new request, giving a grant in the same cycle.
- Outside RD, RD_LAST and WR: mem_we = 0 and mem_addr holds its last value.
- Starvation: with LOADER_FIRST=1, a continuously asserted load_req starves fetch. This is intended while booting.

Test Plan:
- Loader, aligned:
  - Stimulus: load_req, addr 0x10, data 0x00188893.
  - Response: load_gnt at T; T+1..T+4 write 0x93, 0x88, 0x18, 0x00 to 0x10..0x13; load_done at T+5.
- Fetch after load:
  - Stimulus: fetch_req, addr 0x10.
  - Response: fetch_gnt at T; mem_addr 0x10..0x13 at T+1..T+4; fetch_valid at T+6 with fetch_instr = 0x00188893.
- Simultaneous requests, LOADER_FIRST=1:
  - Stimulus: fetch_req and load_req both asserted.
  - Response: load_gnt first; fetch_gnt in the load_done cycle (T+5); fetch_valid at T+11.
- Misaligned and out-of-range:
  - Stimulus: fetch_addr 0x22; load_addr 0xFC with MEM_BYTES=256 (accepted, since 0xFC = MEM_BYTES-4); load_addr 0x100.
  - Response: fetch_err at T+1 with no memory access; 0xFC writes normally; 0x100 gives load_err at T+1 with mem_we never high.
- Reset mid-write:
  - Stimulus: assert reset in T+2 of a write.
  - Response: mem_we = 0 and busy = 0 from T+3; no load_done; all outputs 0.
- Wrap-safety:
  - Stimulus: fetch_addr 0xFFFFFFFFFFFFFFFC.
  - Response: fetch_err pulse; no 64-bit wrap access.
